// File: rtl/de4_qsys_div_pkg.sv
// Shared constants and FSM encoding for the Nios II radix-2 restoring divide cell.
package de4_qsys_div_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    localparam logic [DATA_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/de4_qsys_nios2_qsys_div_cell.sv
// Multi-cycle signed/unsigned 32-bit divider: one restoring step per cycle on magnitudes,
// followed by a single sign-correction cycle that loads the architectural result registers.
module de4_qsys_nios2_qsys_div_cell #(
    parameter int DATA_W = de4_qsys_div_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    input  logic [DATA_W-1:0] E_src1_div,
    input  logic [DATA_W-1:0] E_src2_div,
    input  logic              A_div_abort,
    output logic              div_busy,
    output logic              A_div_done,
    output logic [DATA_W-1:0] A_div_quotient,
    output logic [DATA_W-1:0] A_div_remainder
);

    import de4_qsys_div_pkg::*;

    function automatic logic [DATA_W-1:0] abs_if(input logic [DATA_W-1:0] v, input logic sg);
        return (sg && v[DATA_W-1]) ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    div_state_e        r_state;
    div_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvsr;
    logic              r_q_neg;
    logic              r_r_neg;
    logic              r_div0;
    logic [DATA_W-1:0] r_quotient;
    logic [DATA_W-1:0] r_remainder;

    logic              w_idle_or_done;
    logic              w_accept;
    logic              w_last;
    logic [DATA_W:0]   w_rem_sh;
    logic              w_ge;
    logic [DATA_W-1:0] w_sub;

    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    // A flush in the same cycle as a request drops the request.
    assign w_accept       = w_idle_or_done && E_div_start && !A_div_abort;
    assign w_last         = (r_cnt == CNT_W'(ITER_COUNT - 1));

    // The partial remainder is always below the divisor, so the 32-bit wrapped
    // difference is exact whenever the trial subtraction succeeds.
    assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_sub    = w_rem_sh[DATA_W-1:0] - r_dvsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_ITER;
            S_ITER: begin
                if (A_div_abort)  w_state_nxt = S_IDLE;
                else if (w_last)  w_state_nxt = S_FIX;
            end
            S_FIX:  w_state_nxt = A_div_abort ? S_IDLE : S_DONE;
            S_DONE: w_state_nxt = w_accept ? S_ITER : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the working registers are plain flops, not a memory, so they are reset to a known zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_div0      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= abs_if(E_src1_div, E_div_signed);
            r_dvsr  <= abs_if(E_src2_div, E_div_signed);
            r_q_neg <= E_div_signed && (E_src1_div[DATA_W-1] ^ E_src2_div[DATA_W-1]);
            r_r_neg <= E_div_signed && E_src1_div[DATA_W-1];
            r_div0  <= (E_src2_div == '0);
        end else if (r_state == S_ITER && !A_div_abort) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_rem <= w_ge ? w_sub : w_rem_sh[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
        end else if (r_state == S_FIX && !A_div_abort) begin
            // With a zero divisor the magnitude remainder is |dividend|, so the usual
            // remainder sign fix restores the original dividend; only the quotient is forced.
            r_quotient  <= r_div0 ? DIV0_QUOTIENT : neg_if(r_quo, r_q_neg);
            r_remainder <= neg_if(r_rem, r_r_neg);
        end
    end

    assign div_busy        = (r_state == S_ITER) || (r_state == S_FIX);
    assign A_div_done      = (r_state == S_DONE);
    assign A_div_quotient  = r_quotient;
    assign A_div_remainder = r_remainder;

endmodule

// File: tb/tb_de4_qsys_nios2_qsys_div_cell.sv
// Directed self-checking bench for the divide cell: latency, sign rules, divide-by-zero,
// abort, reset mid-operation and back-to-back starts.
module tb_de4_qsys_nios2_qsys_div_cell;

    logic        clk;
    logic        reset_n;
    logic        E_div_start;
    logic        E_div_signed;
    logic [31:0] E_src1_div;
    logic [31:0] E_src2_div;
    logic        A_div_abort;
    logic        div_busy;
    logic        A_div_done;
    logic [31:0] A_div_quotient;
    logic [31:0] A_div_remainder;

    int errors = 0;
    int checks = 0;

    de4_qsys_nios2_qsys_div_cell #(.DATA_W(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .E_div_start     (E_div_start),
        .E_div_signed    (E_div_signed),
        .E_src1_div      (E_src1_div),
        .E_src2_div      (E_src2_div),
        .A_div_abort     (A_div_abort),
        .div_busy        (div_busy),
        .A_div_done      (A_div_done),
        .A_div_quotient  (A_div_quotient),
        .A_div_remainder (A_div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the start edge (cycle 1 of the operation).
    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic sg);
        E_src1_div   = a;
        E_src2_div   = b;
        E_div_signed = sg;
        E_div_start  = 1'b1;
        @(posedge clk);
        #1;
        E_div_start  = 1'b0;
    endtask

    // Advances until done is seen (bounded); lat is the cycle number after the start edge.
    task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
        lat      = lat0;
        busy_cnt = 0;
        while (A_div_done !== 1'b1 && lat < 80) begin
            if (div_busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic expect_no_done(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (A_div_done === 1'b1) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [31:0] exp_q, input logic [31:0] exp_r);
        int lat;
        int busy_cnt;
        do_start(a, b, sg);
        wait_done(1, lat, busy_cnt);
        check({tag, "_lat"}, lat, 34);
        check({tag, "_q"}, A_div_quotient, exp_q);
        check({tag, "_r"}, A_div_remainder, exp_r);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, A_div_done, 1'b0);
    endtask

    initial begin
        int lat;
        int busy_cnt;

        reset_n      = 1'b0;
        E_div_start  = 1'b0;
        E_div_signed = 1'b0;
        E_src1_div   = '0;
        E_src2_div   = '0;
        A_div_abort  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", div_busy, 1'b0);
        check("rst_done", A_div_done, 1'b0);
        check("rst_q", A_div_quotient, 32'h0);
        check("rst_r", A_div_remainder, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned 100/7 with full busy/latency profile.
        do_start(32'd100, 32'd7, 1'b0);
        wait_done(1, lat, busy_cnt);
        check("u100_7_lat", lat, 34);
        check("u100_7_busy", busy_cnt, 33);
        check("u100_7_q", A_div_quotient, 32'd14);
        check("u100_7_r", A_div_remainder, 32'd2);
        @(posedge clk);
        #1;
        check("u100_7_done_pulse", A_div_done, 1'b0);

        run_op("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run_op("s_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2);
        run_op("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
        run_op("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0);
        run_op("u_min_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
        run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'h0);

        // Start while busy is ignored: result and latency belong to the first request.
        do_start(32'd1000, 32'd33, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        do_start(32'd9, 32'd3, 1'b0);
        wait_done(6, lat, busy_cnt);
        check("busy_start_lat", lat, 34);
        check("busy_start_q", A_div_quotient, 32'd30);
        check("busy_start_r", A_div_remainder, 32'd10);
        @(posedge clk);
        #1;

        // Abort 10 cycles into an operation.
        do_start(32'd1000, 32'd10, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        A_div_abort = 1'b1;
        @(posedge clk);
        #1;
        A_div_abort = 1'b0;
        check("abort_busy", div_busy, 1'b0);
        check("abort_q_hold", A_div_quotient, 32'd30);
        check("abort_r_hold", A_div_remainder, 32'd10);
        expect_no_done("abort_no_done", 40);
        run_op("after_abort_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

        // Abort and start together in IDLE: the start is dropped.
        E_src1_div  = 32'd50;
        E_src2_div  = 32'd5;
        E_div_start = 1'b1;
        A_div_abort = 1'b1;
        @(posedge clk);
        #1;
        E_div_start = 1'b0;
        A_div_abort = 1'b0;
        check("abort_start_busy", div_busy, 1'b0);
        expect_no_done("abort_start_no_done", 40);
        check("abort_start_q_hold", A_div_quotient, 32'd3);

        // Reset asserted 20 cycles into an operation clears outputs asynchronously.
        do_start(32'd100, 32'd7, 1'b0);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", div_busy, 1'b0);
        check("midrst_done", A_div_done, 1'b0);
        check("midrst_q", A_div_quotient, 32'h0);
        check("midrst_r", A_div_remainder, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expect_no_done("midrst_no_done", 40);

        // Back-to-back: the first start after reset, then a second start accepted in DONE.
        do_start(32'd100, 32'd7, 1'b0);
        wait_done(1, lat, busy_cnt);
        check("b2b_a_lat", lat, 34);
        check("b2b_a_q", A_div_quotient, 32'd14);
        do_start(32'hFFFF_FF9C, 32'd7, 1'b1);
        check("b2b_b_busy", div_busy, 1'b1);
        wait_done(1, lat, busy_cnt);
        check("b2b_b_lat", lat, 34);
        check("b2b_b_q", A_div_quotient, 32'hFFFF_FFF2);
        check("b2b_b_r", A_div_remainder, 32'hFFFF_FFFE);

        // Abort while in DONE has no effect on the results.
        A_div_abort = 1'b1;
        @(posedge clk);
        #1;
        A_div_abort = 1'b0;
        check("done_abort_done", A_div_done, 1'b0);
        check("done_abort_q", A_div_quotient, 32'hFFFF_FFF2);
        check("done_abort_r", A_div_remainder, 32'hFFFF_FFFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/de4_qsys_nios2_qsys_div_cell.md
DE4_QSYS_NIOS2_QSYS_DIV_CELL -- requirements
Module: de4_qsys_nios2_qsys_div_cell

Interface
REQ-001 Parameter: DATA_W, 32, operand and result width; only 32 is supported.
REQ-002 Port: clk  in  1  sole clock; all registers rise-edge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: E_div_start  in  1  single-cycle request; operands valid this cycle.
REQ-005 Port: E_div_signed  in  1  1 = signed two's-complement divide, 0 = unsigned.
REQ-006 Port: E_src1_div  in  32  dividend.
REQ-007 Port: E_src2_div  in  32  divisor.
REQ-008 Port: A_div_abort  in  1  pipeline flush; kills the operation in flight.
REQ-009 Port: div_busy  out  1  high while the state is ITER or FIX.
REQ-010 Port: A_div_done  out  1  one-cycle pulse; results valid.
REQ-011 Port: A_div_quotient  out  32  quotient register.
REQ-012 Port: A_div_remainder  out  32  remainder register.

Function
REQ-013 The divider SHALL be a radix-2 restoring divider with FSM states IDLE, ITER, FIX and DONE.
REQ-014 In IDLE or DONE, E_div_start=1 SHALL be accepted on that edge:
- latch |dividend| and |divisor| (absolute values only when E_div_signed=1);
- latch the quotient sign, the remainder sign and a divide-by-zero flag;
- clear the 6-bit iteration counter;
- go to ITER.
REQ-015 E_div_start while busy SHALL be ignored, with no state change.
REQ-016 ITER SHALL perform one shift/subtract/restore step per cycle for exactly 32 cycles, then go to FIX.
REQ-017 FIX SHALL apply sign correction and load A_div_quotient and A_div_remainder, then go to DONE.
REQ-018 DONE SHALL assert A_div_done for exactly one cycle, then go to IDLE unless a new start is accepted.
REQ-019 Latency: A_div_done SHALL be high in the 34th cycle after the start edge (1 accept + 32 ITER + 1 FIX).
REQ-020 Signed mode sign rules:
- quotient negated when the operand signs differ;
- remainder carries the dividend sign;
- identity: dividend = q*divisor + r.
REQ-021 Divisor 0, either mode: quotient SHALL be 0xFFFFFFFF, remainder SHALL equal the original dividend, and latency SHALL be unchanged.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-023 A_div_abort=1 in ITER or FIX:
- SHALL return the FSM to IDLE on that edge;
- A_div_done SHALL NOT be asserted;
- result registers SHALL keep their previous values.
REQ-024 A_div_abort in IDLE or DONE SHALL have no effect on state or outputs.
REQ-025 Abort and start in the same cycle: abort SHALL win and the start SHALL be dropped.
REQ-026 A_div_quotient and A_div_remainder SHALL hold their values until the next FIX.
REQ-027 Back-to-back operation: a start accepted in DONE SHALL give a next done 34 cycles later, with no idle gap.

Reset
REQ-028 While reset_n=0, asynchronously:
- FSM = IDLE;
- counter = 0;
- working registers = 0;
- div_busy = 0, A_div_done = 0;
- A_div_quotient = 0, A_div_remainder = 0.
REQ-029 Reset asserted mid-operation SHALL discard the operation; no done SHALL follow the release of reset.
REQ-030 The first accepted start after reset release SHALL behave identically to any other start.

Structure
REQ-031 The shared package de4_qsys_div_pkg SHALL hold:
- the FSM state enum;
- DATA_W;
- the ITER count constant (32);
- the divide-by-zero quotient constant 0xFFFFFFFF.
REQ-032 The block SHALL be a single module with no sub-modules; the abs/negate logic SHALL be local functions or expressions.
REQ-033 No vendor megafunction or DSP primitive SHALL be instantiated.

Verification
REQ-034 Unsigned 100/7 -> q=14, r=2; done exactly 34 cycles after the start edge; busy high for 33 cycles.
REQ-035 Signed -100/7 (0xFFFFFF9C/0x7) -> q=0xFFFFFFF2, r=0xFFFFFFFE; signed 100/-7 -> q=0xFFFFFFF2, r=2.
REQ-036 Divide by zero: 5/0 unsigned and 0xFFFFFFFB/0 signed -> q=0xFFFFFFFF, r=dividend; done at 34 cycles.
REQ-037 Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
REQ-038 Abort 10 cycles after start -> no done, busy low next cycle, outputs unchanged; a following start of 9/3 -> q=3, r=0.
REQ-039 reset_n pulsed low 20 cycles into an operation -> all outputs 0 immediately and no done afterwards; back-to-back starts in DONE -> two dones 34 cycles apart.
